// File: rtl/tff_sched_pkg.sv
// Shared types, defaults and arbitration helpers for the T-flip-flop toggle
// scheduler. The LOCK state only exists when TFF_SCHED_LOCK_EN is defined.
package tff_sched_pkg;

    // Default parameter values for the scheduler
    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // Helpers work on a fixed maximum requester count; unused lanes are zero
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
`ifdef TFF_SCHED_LOCK_EN
        ,
        LOCK  = 2'd2
`endif
    } sched_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Round-robin search: first set bit of req_vec at or after start,
    // wrapping modulo n (start is always below n)
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req_vec,
        input logic [IDX_W-1:0]   start,
        input int unsigned        n
    );
        pick_t       p;
        int unsigned idx;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = 32'(start) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!p.found && req_vec[idx[IDX_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = idx[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

    // One-hot decode of a requester index
    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [MAX_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/tff_toggle_sched_bank.sv
// tff_bank: WIDTH-bit bank of T flip-flops, each bit toggling when its
// enable is high. Synchronous active-high reset clears every bit.
module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_reg;

            // One T flip-flop: invert on enable, clear on reset
            always_ff @(posedge clk) begin
                if (srst) begin
                    bit_reg <= 1'b0;
                end else if (t_en[gi]) begin
                    bit_reg <= ~bit_reg;
                end
            end

            assign q[gi] = bit_reg;
        end
    endgenerate

endmodule

// File: rtl/tff_toggle_sched.sv
// tff_toggle_sched: round-robin scheduler granting at most one requester per
// cycle and applying its toggle mask to a shared T-flip-flop bank.
// Optional feature macro: TFF_SCHED_LOCK_EN (adds lock port and LOCK state,
// letting a granted requester hold the bank for consecutive cycles).
module tff_toggle_sched
    import tff_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] mask,
`ifdef TFF_SCHED_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic                   busy,
    output logic [CNT_W-1:0]       grant_cnt
);

    sched_state_t       state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic               busy_reg;
    logic [CNT_W-1:0]   grant_cnt_reg, grant_cnt_next;

    logic [MAX_REQ-1:0] req_ext;
    logic [WIDTH-1:0]   mask_arr [MAX_REQ];
    pick_t              rr_sel;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [MAX_REQ-1:0] win_onehot;
    logic [WIDTH-1:0]   toggle_en;

`ifdef TFF_SCHED_LOCK_EN
    logic [MAX_REQ-1:0] lock_ext;
    logic [IDX_W-1:0]   lock_idx_reg;
    logic               lock_hold;
`endif

    // Split the flat mask bus into per-requester lanes; spare lanes read zero
    genvar gi;
    generate
        for (gi = 0; gi < MAX_REQ; gi++) begin : g_mask
            if (gi < N_REQ) begin : g_used
                assign mask_arr[gi] = mask[gi*WIDTH +: WIDTH];
            end else begin : g_spare
                assign mask_arr[gi] = '0;
            end
        end
    endgenerate

    // Widen request (and lock) vectors to the helper width
    always_comb begin
        req_ext             = '0;
        req_ext[N_REQ-1:0]  = req;
`ifdef TFF_SCHED_LOCK_EN
        lock_ext            = '0;
        lock_ext[N_REQ-1:0] = lock;
`endif
    end

    assign rr_sel = rr_pick(req_ext, ptr_reg, 32'(N_REQ));

`ifdef TFF_SCHED_LOCK_EN
    assign lock_hold = (state_reg == LOCK) && req_ext[lock_idx_reg] && lock_ext[lock_idx_reg];
`endif

    // Select the winner: a held lock overrides the round-robin choice
    always_comb begin
        win_found = rr_sel.found;
        win_idx   = rr_sel.idx;
`ifdef TFF_SCHED_LOCK_EN
        if (lock_hold) begin
            win_found = 1'b1;
            win_idx   = lock_idx_reg;
        end
`endif
    end

    assign win_onehot = onehot(win_idx);
    assign toggle_en  = win_found ? mask_arr[win_idx] : '0;

    // Next-state, pointer, grant and counter computation
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = win_found ? GRANT : IDLE;
            GRANT:   state_next = win_found ? GRANT : IDLE;
`ifdef TFF_SCHED_LOCK_EN
            LOCK:    state_next = win_found ? GRANT : IDLE;
`endif
            default: state_next = IDLE;
        endcase
`ifdef TFF_SCHED_LOCK_EN
        if (win_found && lock_ext[win_idx]) begin
            state_next = LOCK;
        end
`endif

        ptr_next       = ptr_reg;
        grant_cnt_next = grant_cnt_reg;
        gnt_next       = N_REQ'(win_found ? win_onehot : '0);
        if (win_found) begin
            // Step past the winner so it waits behind every other requester
            ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            if (grant_cnt_reg != '1) begin
                grant_cnt_next = grant_cnt_reg + CNT_W'(1);
            end
        end
    end

    // FSM state and registered outputs; reset discards any in-flight grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            busy_reg      <= 1'b0;
            grant_cnt_reg <= '0;
`ifdef TFF_SCHED_LOCK_EN
            lock_idx_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnt_reg       <= gnt_next;
            busy_reg      <= win_found;
            grant_cnt_reg <= grant_cnt_next;
`ifdef TFF_SCHED_LOCK_EN
            if (win_found) begin
                lock_idx_reg <= win_idx;
            end
`endif
        end
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk  (clk),
        .srst (rst),
        .t_en (toggle_en),
        .q    (q)
    );

    assign gnt       = gnt_reg;
    assign busy      = busy_reg;
    assign grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Scoreboard bench for tff_toggle_sched: stimulus pushes the hand-computed
// grant it expects, a negedge monitor pops and compares each presented grant.
module tb_tff_toggle_sched;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] mask;
`ifdef TFF_SCHED_LOCK_EN
    logic [N_REQ-1:0]       lock;
`endif
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic [CNT_W-1:0]       grant_cnt;

    typedef struct {
        logic [N_REQ-1:0] gnt;
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    tff_toggle_sched #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
`ifdef TFF_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .q         (q),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N_REQ-1:0] g, input logic [WIDTH-1:0] qv, input logic [CNT_W-1:0] c);
        exp_t e;
        e.gnt = g;
        e.q   = qv;
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_drained"}, 32'(sb.size()), 32'h0);
    endtask

    // Monitor: every presented grant must match the oldest expectation
    always @(negedge clk) begin
        if (busy || gnt != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got gnt=%b busy=%b expected no grant", gnt, busy);
            end else begin
                mon_e = sb.pop_front();
                $display("grant gnt=%b q=%h cnt=%0d", gnt, q, grant_cnt);
                chk("grant_gnt",  32'(gnt),       32'(mon_e.gnt));
                chk("grant_q",    32'(q),         32'(mon_e.q));
                chk("grant_cnt",  32'(grant_cnt), 32'(mon_e.cnt));
                chk("grant_busy", 32'(busy),      32'h1);
            end
        end
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        mask = {8'h08, 8'h04, 8'h02, 8'h01};
`ifdef TFF_SCHED_LOCK_EN
        lock = '0;
`endif
        // Reset held two cycles with every requester active
        step();
        step();
        chk("rst_q",   32'(q),         32'h0);
        chk("rst_cnt", 32'(grant_cnt), 32'h0);
        chk_idle("rst");
        rst = 1'b0;
        req = '0;
        step();
        chk_idle("post_rst");
        chk("post_rst_q", 32'(q), 32'h0);

        // Single requester re-granted three cycles in a row
        mask = {8'h08, 8'h04, 8'h0F, 8'h01};
        req  = 4'b0010;
        push(4'b0010, 8'h0F, 3'd1);
        step();
        push(4'b0010, 8'h00, 3'd2);
        step();
        push(4'b0010, 8'h0F, 3'd3);
        step();
        req = '0;
        step();
        chk_drained("single");
        chk_idle("single");

        // Zero mask still counts as a grant (pointer now at requester 2)
        mask = {8'h00, 8'h04, 8'h0F, 8'h01};
        req  = 4'b1000;
        push(4'b1000, 8'h0F, 3'd4);
        step();
        req = '0;
        step();
        chk_drained("zero_mask");
        chk("zero_mask_q", 32'(q), 32'h0F);

        // All requesters streaming; reset pulsed on the third edge
        mask = {8'h08, 8'h04, 8'h02, 8'h01};
        req  = 4'b1111;
        push(4'b0001, 8'h0E, 3'd5);
        step();
        push(4'b0010, 8'h0C, 3'd6);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_q",   32'(q),         32'h0);
        chk("mid_rst_cnt", 32'(grant_cnt), 32'h0);
        chk_idle("mid_rst");
        rst = 1'b0;

        // Back-to-back round robin from requester 0, wrap, then saturation
        push(4'b0001, 8'h01, 3'd1);
        step();
        push(4'b0010, 8'h03, 3'd2);
        step();
        push(4'b0100, 8'h07, 3'd3);
        step();
        push(4'b1000, 8'h0F, 3'd4);
        step();
        push(4'b0001, 8'h0E, 3'd5);
        step();
        push(4'b0010, 8'h0C, 3'd6);
        step();
        push(4'b0100, 8'h08, 3'd7);
        step();
        push(4'b1000, 8'h00, 3'd7);
        step();
        req = '0;
        step();
        chk_drained("stream");
        chk_idle("stream");
        chk("stream_cnt_sat", 32'(grant_cnt), 32'h7);

`ifdef TFF_SCHED_LOCK_EN
        // Move pointer to 2, then requester 2 holds the bank via lock
        req = 4'b0010;
        push(4'b0010, 8'h02, 3'd7);
        step();
        req  = 4'b0101;
        lock = 4'b0100;
        push(4'b0100, 8'h06, 3'd7);
        step();
        push(4'b0100, 8'h02, 3'd7);
        step();
        push(4'b0100, 8'h06, 3'd7);
        step();
        lock = '0;
        push(4'b0001, 8'h07, 3'd7);
        step();
        req = '0;
        step();
        chk_drained("lock");
        chk_idle("lock");
`endif

        step();
        chk_drained("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
